tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4:1 channel mux. Takes a time-division-multiplexed word stream, one word per slot, 4 slots per frame, with slot 0 flagged by frame_sync.
- Distributes slots to channels a, b, c, d; slot index n corresponds to mux select code {s1,s0}=n.
- Presents each complete frame as one parallel word with a single-cycle valid strobe.
- Sits at the far end of the TDM link, feeding per-channel consumers.

Parameters:
- WIDTH, 1, bits per channel word.
- NUM_CH, 4, channel count; fixed at 4, not overridable. Declared for readability only.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, WIDTH, TDM word for the current slot.
- din_valid, input, 1, din carries a slot word this cycle.
- frame_sync, input, 1, qualifies din as slot 0; ignored when din_valid=0.
- frame_data, output, 4*WIDTH, [WIDTH-1:0]=a, [2W-1:W]=b, [3W-1:2W]=c, [4W-1:3W]=d.
- frame_valid, output, 1, one-cycle strobe: frame_data holds a newly completed frame.
- frame_err, output, 1, one-cycle strobe: framing violation detected.
- locked, output, 1, high in LOCKED state.
- slot, output, 2, slot index expected for the next accepted word.

Behaviour:
- Reset: asynchronous assert on rst_n=0. All outputs go to 0. The state goes to HUNT and the shadow registers go to 0. Release is synchronous to clk.
- Beat: any cycle with din_valid=1. Cycles with din_valid=0 change nothing except clearing the strobes.
- States: HUNT and LOCKED. locked=1 only in LOCKED.
- HUNT, beat with frame_sync=0: discard the beat; stay in HUNT; slot stays 0.
- HUNT, beat with frame_sync=1: store din as a; slot becomes 1; go to LOCKED.
- LOCKED, beat at slot=0 with frame_sync=1: store as a; slot becomes 1.
- LOCKED, beat at slot=0 with frame_sync=0: lost alignment. Pulse frame_err, discard the beat, slot becomes 0, go to HUNT.
- LOCKED, beat at slot 1 or 2 with frame_sync=0: store into shadow b or c; slot increments.
- LOCKED, beat at slot 1, 2 or 3 with frame_sync=1: early sync. Pulse frame_err and drop the partial frame; no frame_valid. Accept the beat as slot 0 (store as a); slot becomes 1; stay in LOCKED.
- LOCKED, beat at slot 3 with frame_sync=0: frame_data loads {din, c, b, a} on that edge. frame_valid=1 for exactly the following cycle. slot wraps to 0.
- Latency: frame_valid is visible one clock after the slot-3 beat is sampled.
- frame_data holds its value until the next completed frame. It is never updated by partial frames or errors.
- frame_valid and frame_err are never high in the same cycle.
- Back-to-back frames with no idle cycles are sustained: a frame_valid strobe every 4 cycles.
- Gaps (din_valid=0) of any length mid-frame are tolerated. There is no timeout.
- Reset mid-frame discards the partial frame. frame_data is cleared and no strobe is issued.

Decomposition:
- Package tdm_pkg holds:
  - state encoding (HUNT=0, LOCKED=1);
  - NUM_CH=4;
  - SLOT_W=2;
  - slot index constants SLOT_A..SLOT_D = 0..3.
- One natural sub-module, tdm_slot_ctr: a 2-bit wrap counter with synchronous load-to-1 and clear, enabled by an accepted beat.
- Shadow registers, the FSM and output registers stay in the top module.

Test Plan:
- WIDTH=4. Reset, then beats 0x1(sync), 0x2, 0x3, 0x4 on consecutive cycles -> one cycle later frame_valid=1 and frame_data=0x4321. locked=1, frame_err=0.
- Two back-to-back frames A,B,C,D then E,F,0,1 -> frame_valid pulses exactly 4 cycles apart with frame_data=0xDCBA, then 0x10FE.
- Three beats without sync after reset -> locked stays 0, no strobes, frame_data=0. The next sync beat sets locked=1 and slot=1.
- Sync at slot 2 (beats 0x5(sync), 0x6, 0x7(sync), 0x8, 0x9, 0xA) -> frame_err pulses on the 3rd beat. The next frame_valid shows frame_data=0xA987.
- After a good frame, a slot-0 beat with frame_sync=0 -> frame_err pulses, locked=0, slot=0, and frame_data keeps its previous value.
- Idle gaps of 3 cycles between each beat -> same frame_data as the gapless case. Asserting rst_n=0 after beat 2 clears all outputs immediately, and no frame_valid follows.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  localparam logic [SLOT_W-1:0] SLOT_A = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_B = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_C = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_D = 2'd3;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: wraps 3->0, loads 1 on a sync beat, clears on lost alignment.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= SLOT_A;
    end else if (en) begin
      if (clr)        cnt <= SLOT_A;
      else if (load1) cnt <= SLOT_B;
      else            cnt <= cnt + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// TDM receive demux: collects four slot words into one parallel frame with
// frame_valid / frame_err strobes and a HUNT/LOCKED alignment FSM.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic                    frame_sync,
  output logic [NUM_CH*WIDTH-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    locked,
  output logic [SLOT_W-1:0]       slot
);

  state_t           state;
  logic [WIDTH-1:0] sh_a, sh_b, sh_c;
  logic             ctr_en, ctr_load1, ctr_clr;

  // A beat moves the counter whenever it is accepted or breaks alignment;
  // beats discarded while hunting leave it parked at 0.
  assign ctr_en    = din_valid && (state == LOCKED || frame_sync);
  assign ctr_load1 = frame_sync;
  assign ctr_clr   = (state == LOCKED) && (slot == SLOT_A) && !frame_sync;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctr_en),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .cnt   (slot)
  );

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      sh_a        <= '0;
      sh_b        <= '0;
      sh_c        <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              sh_a  <= din;
              state <= LOCKED;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // Sync anywhere but slot 0 drops the partial frame and restarts.
              if (slot != SLOT_A) frame_err <= 1'b1;
              sh_a <= din;
            end else begin
              case (slot)
                SLOT_A: begin
                  frame_err <= 1'b1;
                  state     <= HUNT;
                end
                SLOT_B: sh_b <= din;
                SLOT_C: sh_c <= din;
                default: begin
                  frame_data  <= {din, sh_c, sh_b, sh_a};
                  frame_valid <= 1'b1;
                end
              endcase
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with WIDTH=4 and hand-computed expectations.
module tb_tdm_demux4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [4*W-1:0] frame_data;
  logic         frame_valid, frame_err, locked;
  logic [1:0]   slot;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .locked      (locked),
    .slot        (slot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat at the falling edge; return just after the sampling edge.
  task automatic beat(input logic s, input logic [W-1:0] d);
    @(negedge clk);
    din_valid = 1'b1; frame_sync = s; din = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0; frame_sync = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] fd, input logic fv,
                         input logic fe, input logic lk, input logic [1:0] sl);
    chk({tag, ".data"},   32'(frame_data),  32'(fd));
    chk({tag, ".valid"},  32'(frame_valid), 32'(fv));
    chk({tag, ".err"},    32'(frame_err),   32'(fe));
    chk({tag, ".locked"}, 32'(locked),      32'(lk));
    chk({tag, ".slot"},   32'(slot),        32'(sl));
  endtask

  initial begin
    do_reset();
    #1 chk_all("reset", 16'h0000, 0, 0, 0, 2'd0);

    // Basic frame
    beat(1, 4'h1); chk_all("f1.b0", 16'h0000, 0, 0, 1, 2'd1);
    beat(0, 4'h2);
    beat(0, 4'h3); chk_all("f1.b2", 16'h0000, 0, 0, 1, 2'd3);
    beat(0, 4'h4); chk_all("f1.done", 16'h4321, 1, 0, 1, 2'd0);

    // Back-to-back frames, strobes 4 cycles apart
    beat(1, 4'hA); chk("bb.clr", 32'(frame_valid), 0);
    beat(0, 4'hB);
    beat(0, 4'hC);
    beat(0, 4'hD); chk_all("bb.f1", 16'hDCBA, 1, 0, 1, 2'd0);
    beat(1, 4'hE); chk("bb.e.v", 32'(frame_valid), 0);
    beat(0, 4'hF); chk("bb.f.v", 32'(frame_valid), 0);
    beat(0, 4'h0); chk("bb.0.v", 32'(frame_valid), 0);
    beat(0, 4'h1); chk_all("bb.f2", 16'h10FE, 1, 0, 1, 2'd0);

    // Lost alignment at slot 0
    beat(0, 4'h7); chk_all("lost", 16'h10FE, 0, 1, 0, 2'd0);
    idle(1);       chk("lost.errclr", 32'(frame_err), 0);

    // Early sync at slot 2
    beat(1, 4'h5);
    beat(0, 4'h6);
    beat(1, 4'h7); chk_all("early", 16'h10FE, 0, 1, 1, 2'd1);
    beat(0, 4'h8); chk("early.errclr", 32'(frame_err), 0);
    beat(0, 4'h9);
    beat(0, 4'hA); chk_all("early.f", 16'hA987, 1, 0, 1, 2'd0);

    // Hunting discards unsynced beats
    do_reset();
    beat(0, 4'h1);
    beat(0, 4'h2);
    beat(0, 4'h3); chk_all("hunt", 16'h0000, 0, 0, 0, 2'd0);
    beat(1, 4'h5); chk_all("hunt.sync", 16'h0000, 0, 0, 1, 2'd1);

    // Idle gaps mid-frame
    do_reset();
    beat(1, 4'h1); idle(3); chk("gap.slot1", 32'(slot), 1);
    beat(0, 4'h2); idle(3);
    beat(0, 4'h3); idle(3); chk_all("gap.hold", 16'h0000, 0, 0, 1, 2'd3);
    beat(0, 4'h4); chk_all("gap.f", 16'h4321, 1, 0, 1, 2'd0);
    idle(1);

    // Reset mid-frame
    beat(1, 4'h9);
    beat(0, 4'h8);
    #1 rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    #1 chk_all("rstmid", 16'h0000, 0, 0, 0, 2'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rstmid.novalid", 32'(frame_valid), 0);
    end
    chk_all("rstmid.end", 16'h0000, 0, 0, 0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
